// File: rtl/seqbnn_engine.sv
// seqbnn_engine: two-layer sequential binarized-network inference engine.
// A sample of N unsigned B-bit features is reduced to M binary hidden
// activations (one neuron per cycle), then scored against C classes by
// xnor-popcount (one class per cycle), with a running argmax.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-low reset
//   in_valid   input sample valid
//   in_ready   engine can accept a sample (high only in IDLE)
//   data       features, x_i = data[i*B +: B]
//   out_valid  result valid, held until out_ready
//   out_ready  consumer accepts result
//   sums       class scores, sums[k*SL +: SL] = score of class k
//   class_idx  first index of the maximal score
//   busy       high while computing layer 1 or layer 2
module seqbnn_engine #(
    parameter int unsigned N = 4,
    parameter int unsigned B = 4,
    parameter int unsigned M = 4,
    parameter int unsigned C = 4,
    parameter logic [M*N-1:0] W1 = '1,
    parameter logic [M*(B+$clog2(N)+1)-1:0] T1 = '0,
    parameter logic [C*M-1:0] W2 = '1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [N*B-1:0]                      data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [C*$clog2(M+1)-1:0]            sums,
    output logic [((C > 1) ? $clog2(C) : 1)-1:0] class_idx,
    output logic                                busy
);

    localparam int unsigned AW = B + $clog2(N) + 1;
    localparam int unsigned SL = $clog2(M + 1);
    localparam int unsigned JW = (M > 1) ? $clog2(M) : 1;
    localparam int unsigned KW = (C > 1) ? $clog2(C) : 1;

    typedef enum logic [1:0] {IDLE, L1, L2, HOLD} state_t;

    state_t          state_q;
    state_t          state_n;
    logic [N*B-1:0]  data_q;
    logic [M-1:0]    h_q;
    logic [JW-1:0]   j_q;
    logic [KW-1:0]   k_q;
    logic [SL-1:0]   max_q;

    logic signed [AW-1:0] acc_c;
    logic                 h_bit_c;
    logic [M-1:0]         match_c;
    logic [SL-1:0]        score_c;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // Next-state logic; in_ready is only high in IDLE, so in_valid alone qualifies the accept
    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_n = L1;
            L1:      if (j_q == JW'(M - 1)) state_n = L2;
            L2:      if (k_q == KW'(C - 1)) state_n = HOLD;
            HOLD:    if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Layer-1 neuron j: signed weighted sum of the captured features against its threshold
    always_comb begin
        acc_c = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (W1[int'(j_q) * int'(N) + i]) begin
                acc_c = acc_c + $signed(AW'(data_q[i*B +: B]));
            end else begin
                acc_c = acc_c - $signed(AW'(data_q[i*B +: B]));
            end
        end
        h_bit_c = (acc_c >= $signed(T1[int'(j_q) * int'(AW) +: AW]));
    end

    // Layer-2 class k: xnor-popcount of the hidden vector against the class weights
    always_comb begin
        match_c = ~(h_q ^ W2[int'(k_q) * int'(M) +: M]);
        score_c = '0;
        for (int b = 0; b < int'(M); b++) begin
            score_c = score_c + SL'(match_c[b]);
        end
    end

    // Datapath and registered handshake outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            sums      <= '0;
            class_idx <= '0;
            data_q    <= '0;
            h_q       <= '0;
            j_q       <= '0;
            k_q       <= '0;
            max_q     <= '0;
        end else begin
            in_ready  <= (state_n == IDLE);
            out_valid <= (state_n == HOLD);
            busy      <= (state_n == L1) || (state_n == L2);
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        data_q <= data;
                        j_q    <= '0;
                    end
                end
                L1: begin
                    h_q[j_q] <= h_bit_c;
                    j_q      <= j_q + JW'(1);
                    if (j_q == JW'(M - 1)) k_q <= '0;
                end
                L2: begin
                    sums[int'(k_q) * int'(SL) +: SL] <= score_c;
                    // Strict greater-than keeps the lowest index on ties
                    if ((k_q == '0) || (score_c > max_q)) begin
                        max_q     <= score_c;
                        class_idx <= k_q;
                    end
                    k_q <= k_q + KW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seqbnn_engine.sv
// Bench for seqbnn_engine: five differently-weighted instances share one
// stimulus stream; each result is compared to an integer reference model.
module tb_seqbnn_engine;

    localparam int NI = 5;
    // Instance 0: defaults; 1: tie argmax; 2: thresholds; 3: argmax=1; 4: mixed signs
    localparam logic [NI-1:0][15:0] W1S = {16'h3C5A, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    localparam logic [NI-1:0][27:0] T1S = {
        {7'h7D, 7'h00, 7'h07, 7'h74},
        28'h0,
        {7'h0A, 7'h7B, 7'h1E, 7'h3D},
        28'h0,
        28'h0};
    localparam logic [NI-1:0][15:0] W2S = {
        16'hA5C3,
        16'b1001_0110_1111_0111,
        16'b1111_0011_1111_1110,
        16'b0000_0011_1111_1111,
        16'hFFFF};

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] data;
    logic        in_ready_o  [NI];
    logic        out_valid_o [NI];
    logic        busy_o      [NI];
    logic [11:0] sums_o      [NI];
    logic [1:0]  idx_o       [NI];

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        seqbnn_engine #(
            .N(4), .B(4), .M(4), .C(4),
            .W1(W1S[g]), .T1(T1S[g]), .W2(W2S[g])
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .in_valid(in_valid),
            .in_ready(in_ready_o[g]),
            .data(data),
            .out_valid(out_valid_o[g]),
            .out_ready(out_ready),
            .sums(sums_o[g]),
            .class_idx(idx_o[g]),
            .busy(busy_o[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic over the network definition
    function automatic void model(input int n, input logic [15:0] d,
                                 output logic [11:0] s, output logic [1:0] idx);
        int acc;
        int sc;
        int best;
        logic signed [6:0] t;
        logic [3:0] h;
        for (int j = 0; j < 4; j++) begin
            acc = 0;
            for (int i = 0; i < 4; i++) begin
                if (W1S[n][j*4+i]) acc += int'(d[i*4 +: 4]);
                else               acc -= int'(d[i*4 +: 4]);
            end
            t = T1S[n][j*7 +: 7];
            h[j] = (acc >= int'(t));
        end
        best = -1;
        idx  = 2'd0;
        s    = '0;
        for (int k = 0; k < 4; k++) begin
            sc = 0;
            for (int b = 0; b < 4; b++) if (h[b] == W2S[n][k*4+b]) sc++;
            s[k*3 +: 3] = 3'(sc);
            if (sc > best) begin
                best = sc;
                idx  = 2'(k);
            end
        end
    endfunction

    task automatic check_all_results(input logic [15:0] d);
        logic [11:0] es;
        logic [1:0]  ei;
        for (int n = 0; n < NI; n++) begin
            model(n, d, es, ei);
            check($sformatf("sums[%0d] d=%h", n, d), 32'(sums_o[n]), 32'(es));
            check($sformatf("idx[%0d] d=%h", n, d), 32'(idx_o[n]), 32'(ei));
        end
    endtask

    // One transaction, entered and left on a negedge with the engine in IDLE
    task automatic run_txn(input logic [15:0] d, input int hold, input bit fast);
        int cyc;
        int nbusy;
        logic [11:0] snap;
        logic [1:0]  snap_idx;
        check("idle_in_ready", 32'(in_ready_o[0]), 32'd1);
        in_valid  = 1'b1;
        data      = d;
        out_ready = fast;
        @(negedge clk);
        in_valid = 1'b0;
        cyc   = 0;
        nbusy = 0;
        while (!out_valid_o[0] && cyc < 40) begin
            if (busy_o[0]) nbusy++;
            if (in_ready_o[0]) check("in_ready_while_busy", 32'd1, 32'd0);
            in_valid = 1'($urandom_range(1));
            data     = 16'($urandom);
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        check("latency", 32'(cyc), 32'd8);
        check("busy_cycles", 32'(nbusy), 32'd8);
        check("busy_in_hold", 32'(busy_o[0]), 32'd0);
        check_all_results(d);
        if (fast) begin
            @(negedge clk);
            check("fast_out_valid", 32'(out_valid_o[0]), 32'd0);
            check("fast_in_ready", 32'(in_ready_o[0]), 32'd1);
        end else begin
            snap     = sums_o[0];
            snap_idx = idx_o[0];
            for (int c = 0; c < hold; c++) begin
                in_valid = 1'($urandom_range(1));
                data     = 16'($urandom);
                @(negedge clk);
                check("bp_out_valid", 32'(out_valid_o[0]), 32'd1);
                check("bp_in_ready", 32'(in_ready_o[0]), 32'd0);
                check("bp_sums", 32'(sums_o[0]), 32'(snap));
                check("bp_idx", 32'(idx_o[0]), 32'(snap_idx));
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            @(negedge clk);
            check("rel_out_valid", 32'(out_valid_o[0]), 32'd0);
            check("rel_in_ready", 32'(in_ready_o[0]), 32'd1);
        end
        out_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        data      = 16'h0;
        repeat (3) @(negedge clk);
        for (int n = 0; n < NI; n++) begin
            check($sformatf("rst_in_ready[%0d]", n), 32'(in_ready_o[n]), 32'd1);
            check($sformatf("rst_out_valid[%0d]", n), 32'(out_valid_o[n]), 32'd0);
            check($sformatf("rst_busy[%0d]", n), 32'(busy_o[n]), 32'd0);
            check($sformatf("rst_sums[%0d]", n), 32'(sums_o[n]), 32'd0);
            check($sformatf("rst_idx[%0d]", n), 32'(idx_o[n]), 32'd0);
        end
        rst = 1'b1;
        @(negedge clk);

        // All-15 sample with the consumer already ready
        run_txn(16'hFFFF, 0, 1'b1);
        // Hand-derived scores for the all-15 sample (HOLD is already consumed, values persist)
        check("dir_default_sums", 32'(sums_o[0]), 32'h924);
        check("dir_default_idx", 32'(idx_o[0]), 32'd0);
        check("dir_tie_sums", 32'(sums_o[1]), 32'h0A4);
        check("dir_tie_idx", 32'(idx_o[1]), 32'd0);
        check("dir_thr_sums", 32'(sums_o[2]), 32'h65C);
        check("dir_thr_idx", 32'(idx_o[2]), 32'd0);
        check("dir_arg1_sums", 32'(sums_o[3]), 32'h4A3);
        check("dir_arg1_idx", 32'(idx_o[3]), 32'd1);

        // Back-pressure for 10 cycles with in_valid noise
        run_txn(16'h3A5C, 10, 1'b0);

        // Randomized samples, hold lengths and consumer readiness
        for (int r = 0; r < 25; r++) begin
            run_txn(16'($urandom), int'($urandom_range(3)), 1'($urandom_range(1)));
        end

        // Reset while layer 2 is on class 2
        in_valid = 1'b1;
        data     = 16'h1234;
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("abort_no_out_valid", 32'(out_valid_o[0]), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("abort_in_ready", 32'(in_ready_o[0]), 32'd1);
        check("abort_busy", 32'(busy_o[0]), 32'd0);
        for (int n = 0; n < NI; n++) begin
            check($sformatf("abort_sums[%0d]", n), 32'(sums_o[n]), 32'd0);
            check($sformatf("abort_idx[%0d]", n), 32'(idx_o[n]), 32'd0);
        end
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check("abort_stays_idle", 32'(out_valid_o[0]), 32'd0);
        end

        // Engine recovers cleanly after the abort
        run_txn(16'hC0DE, 2, 1'b0);
        run_txn(16'($urandom), 0, 1'b1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/seqbnn_engine.md
# seqbnn_engine

Two-layer sequential binarized-network inference engine with valid/ready handshakes at both ends. A sample of N unsigned B-bit features is accepted, reduced serially to M binary hidden activations, then classified serially into C xnor-popcount scores. The engine also produces an argmax class index. It replaces the fixed done-strobe chaining of separate layer blocks with one controller that supports back-pressure and holds results until they are consumed.

## Interface
Parameters:
- N, 4, number of input features
- B, 4, bits per input feature (unsigned)
- M, 4, number of hidden neurons (layer 1)
- C, 4, number of classes (layer 2)
- W1, all ones, M*N-bit layer-1 sign weights; bit [j*N+i]=1 adds x_i to neuron j, 0 subtracts it
- T1, 0, M*AW-bit packed signed layer-1 thresholds, AW = B+$clog2(N)+1
- W2, all ones, C*M-bit layer-2 binary weights, slice [k*M +: M] for class k

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset
- in_valid  in  1  input sample valid
- in_ready  out  1  engine can accept a sample
- data  in  N*B  features; x_i = data[i*B +: B]
- out_valid  out  1  result valid, held until accepted
- out_ready  in  1  consumer accepts result
- sums  out  C*SL  class scores, SL=$clog2(M+1); sums[k*SL +: SL] = score of class k
- class_idx  out  $clog2(C) (min 1)  argmax of sums
- busy  out  1  high in L1 or L2

## Operation
- Reset: when rst=0 at a rising edge, state→IDLE. Outputs after reset: in_ready=1, out_valid=0, busy=0, sums=0, class_idx=0. All internal counters, the hidden register, and the captured data are cleared. Reset aborts any transaction in progress; the aborted sample produces no result.
- The FSM has four states: IDLE, L1, L2 and HOLD.
- IDLE: in_ready=1. On in_valid&&in_ready, the engine captures data into an internal register, clears j, and moves to L1.
- L1: one neuron per cycle, j=0..M-1.
  - acc_j = Σ_i (W1[j*N+i] ? +x_i : −x_i). The sum is signed AW bits, with no overflow by construction.
  - h[j] = (acc_j >= T1[j]) as a signed compare.
  - After j=M-1 the engine clears k and moves to L2.
- L2: one class per cycle, k=0..C-1.
  - score_k = popcount(~(h ^ W2[k])), giving a value in 0..M.
  - The score is written to sums slice k.
  - A running maximum is kept. Ties keep the lower index, so class_idx is the first maximal index.
  - After k=C-1 the engine moves to HOLD.
- HOLD: out_valid=1, while sums and class_idx remain stable. On out_ready, the engine goes to IDLE with out_valid=0 on the next cycle.
  - sums and class_idx keep their last values until overwritten by the next transaction's L2.
- in_ready is 0 in L1, L2 and HOLD. in_valid in those states is ignored. data is not sampled outside the capture edge.
- No result is ever dropped. A new sample is accepted only after the current result has been consumed.
- busy = (state==L1 || state==L2).

## Timing
- Accept edge t (IDLE, in_valid=1).
- L1 occupies edges t+1..t+M.
- L2 occupies edges t+M+1..t+M+C.
- out_valid rises after edge t+M+C, so input-to-result latency is M+C cycles.
- If out_ready is already 1 when out_valid rises, the result is consumed at the next edge: HOLD lasts 1 cycle, and in_ready=1 the cycle after.
- Minimum transaction period is M+C+2 cycles: accept cycle, M cycles, C cycles, HOLD cycle.
- There are no combinational paths from in_valid or out_ready to any output.
- Reset asserted in any state takes priority over the handshakes at that edge.

## Test plan
- Reset values: hold rst=0 for 3 cycles, then release. Required: in_ready=1, out_valid=0, busy=0, sums=0, class_idx=0.
- Defaults, data=16'hFFFF (x_i=15): every acc=60≥0, so h=4'b1111. With W2 all ones, every score=4, sums=12'h924 (SL=3) and class_idx=0. out_valid is high exactly 8 cycles after the accept edge.
- Argmax and ties, W2 = {4'b0000, 4'b0011, 4'b1111, 4'b1111} (class 3..0), h=4'b1111: scores are 4,4,2,0, so class_idx=0. With W2 class 1 = 4'b1111 and class 0 = 4'b0111, scores are 3,4,…, so class_idx=1.
- Threshold, W1 all ones, T1[0]=61, data all 15: h[0]=0 and h[3:1]=1. Class-0 weight 4'b1110 gives score 4.
- Back-pressure: hold out_ready=0 for 10 cycles after out_valid. sums must stay stable, in_ready=0, and in_valid pulses are ignored. Raising out_ready gives out_valid=0 on the next edge and in_ready=1.
- Reset mid-L2: assert rst=0 when k=2. Required: IDLE on the next edge, out_valid never asserted, sums=0, and the next transaction still completes correctly.
